// File: rtl/fpu_ret_collect.sv
// fpu_ret_collect: per-lane return-tag FIFOs merged round-robin onto one registered retire port
// Define FPU_RET_BYPASS_EN to let a tag skip an empty FIFO straight into the output register.
module fpu_ret_collect #(
   parameter int LANES = 3,
   parameter int RET_W = 14,
   parameter int DEPTH = 4,
   parameter int LW    = 3
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [LANES*RET_W-1:0] i_lane_ret,
   input  logic [LANES-1:0]       i_lane_ret_en,
   output logic [LANES-1:0]       o_lane_stall,
   output logic [LANES-1:0]       o_lane_ovf,
   output logic [RET_W-1:0]       o_ret,
   output logic [LW-1:0]          o_ret_lane,
   output logic                   o_ret_en,
   input  logic                   i_ret_rdy
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [RET_W-1:0] r_mem [LANES][DEPTH];
   logic [PW-1:0]    r_wr [LANES];
   logic [PW-1:0]    r_rd [LANES];
   logic [CW-1:0]    r_cnt [LANES];
   logic [CW-1:0]    w_cnt_nx [LANES];
   logic [LW-1:0]    r_rr;
   logic [LANES-1:0] r_stall, r_ovf;
   logic [RET_W-1:0] r_ret;
   logic [LW-1:0]    r_ret_lane;
   logic             r_ret_en;
   logic             w_free, w_any;
   logic [LW-1:0]    w_gnt;
   logic [RET_W-1:0] w_data;
   logic [LANES-1:0] w_req, w_sel, w_pop, w_byp, w_push, w_drop;
   assign w_free       = !r_ret_en || i_ret_rdy;
   assign o_lane_stall = r_stall;
   assign o_lane_ovf   = r_ovf;
   assign o_ret        = r_ret;
   assign o_ret_lane   = r_ret_lane;
   assign o_ret_en     = r_ret_en;
   // a lane requests the output when its FIFO holds data (or, with bypass, a tag arrives)
   always_comb begin
      w_req = '0;
      for (int i = 0; i < LANES; i++) begin
`ifdef FPU_RET_BYPASS_EN
         w_req[i] = (r_cnt[i] != '0) || i_lane_ret_en[i];
`else
         w_req[i] = r_cnt[i] != '0;
`endif
      end
   end
   // round-robin search from r_rr; scanning backwards leaves the nearest requester as winner
   always_comb begin
      int j;
      j      = 0;
      w_any  = 1'b0;
      w_gnt  = '0;
      w_sel  = '0;
      w_data = '0;
      for (int k = LANES - 1; k >= 0; k--) begin
         j = int'(r_rr) + k;
         j = (j >= LANES) ? j - LANES : j;
         if (w_req[j]) begin
            w_any  = 1'b1;
            w_gnt  = LW'(j);
            w_sel  = '0;
            w_sel[j] = 1'b1;
            w_data = (r_cnt[j] != '0) ? r_mem[j][r_rd[j]] : i_lane_ret[j*RET_W +: RET_W];
         end
      end
   end
   // per-lane pop/push/drop decisions; a full lane still accepts a push when it pops on the same edge
   always_comb begin
      w_pop  = '0;
      w_byp  = '0;
      w_push = '0;
      w_drop = '0;
      for (int i = 0; i < LANES; i++) begin
         w_pop[i]    = w_free && w_sel[i] && (r_cnt[i] != '0);
`ifdef FPU_RET_BYPASS_EN
         w_byp[i]    = w_free && w_sel[i] && (r_cnt[i] == '0) && i_lane_ret_en[i];
`endif
         w_push[i]   = i_lane_ret_en[i] && !w_byp[i] && ((r_cnt[i] != CW'(DEPTH)) || w_pop[i]);
         w_drop[i]   = i_lane_ret_en[i] && (r_cnt[i] == CW'(DEPTH)) && !w_pop[i];
         w_cnt_nx[i] = r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      end
   end
   // FIFO pointers, counts, stall and sticky overflow flags
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < LANES; i++) begin
            r_wr[i]  <= '0;
            r_rd[i]  <= '0;
            r_cnt[i] <= '0;
         end
         r_stall <= '0;
         r_ovf   <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (w_push[i]) r_wr[i] <= r_wr[i] + 1'b1;
            if (w_pop[i]) r_rd[i] <= r_rd[i] + 1'b1;
            if (w_drop[i]) r_ovf[i] <= 1'b1;
            r_cnt[i]   <= w_cnt_nx[i];
            r_stall[i] <= w_cnt_nx[i] >= CW'(DEPTH - 1);
         end
      end
   end
   // FIFO storage needs no reset; pointers alone define validity
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < LANES; i++)
         if (w_push[i]) r_mem[i][r_wr[i]] <= i_lane_ret[i*RET_W +: RET_W];
   end
   // retire register: loads the grant when free, holds while the consumer stalls
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ret      <= '0;
         r_ret_lane <= '0;
         r_ret_en   <= 1'b0;
         r_rr       <= '0;
      end else if (w_free) begin
         r_ret_en <= w_any;
         if (w_any) begin
            r_ret      <= w_data;
            r_ret_lane <= w_gnt;
            r_rr       <= (w_gnt == LW'(LANES - 1)) ? '0 : w_gnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fpu_ret_collect.sv
// tb_fpu_ret_collect: directed scoreboard bench for fpu_ret_collect (default build, no bypass)
module tb_fpu_ret_collect;
   localparam int LANES = 3;
   localparam int RET_W = 14;
   localparam int DEPTH = 4;
   localparam int LW    = 3;
   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [LANES*RET_W-1:0] lane_ret = '0;
   logic [LANES-1:0]       lane_en = '0;
   logic                   ret_rdy = 1'b0;
   logic [LANES-1:0]       stall, ovf;
   logic [RET_W-1:0]       ret;
   logic [LW-1:0]          ret_lane;
   logic                   ret_en;
   logic [LW+RET_W-1:0]    exp_q [$];
   logic [LW+RET_W-1:0]    m_exp;
   int checks = 0;
   int errors = 0;

   fpu_ret_collect #(.LANES(LANES), .RET_W(RET_W), .DEPTH(DEPTH), .LW(LW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_lane_ret(lane_ret), .i_lane_ret_en(lane_en),
      .o_lane_stall(stall), .o_lane_ovf(ovf), .o_ret(ret), .o_ret_lane(ret_lane),
      .o_ret_en(ret_en), .i_ret_rdy(ret_rdy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int lane, input int tag, input bit keep = 1'b1);
      lane_en[lane] = 1'b1;
      lane_ret[lane*RET_W +: RET_W] = RET_W'(tag);
      if (keep) exp_q.push_back({LW'(lane), RET_W'(tag)});
   endtask

   task automatic idle;
      lane_en = '0;
   endtask

   task automatic do_reset;
      lane_en = '0;
      ret_rdy = 1'b0;
      rst_n = 1'b0;
      tick;
      exp_q.delete();
      rst_n = 1'b1;
      tick;
   endtask

   task automatic drain;
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick;
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic chk_out(input string tag, input bit en, input int tag_v, input int lane);
      chk({tag, "_en"}, 32'(ret_en), 32'(en));
      chk({tag, "_ret"}, 32'(ret), 32'(tag_v));
      chk({tag, "_lane"}, 32'(ret_lane), 32'(lane));
   endtask

   // scoreboard: every accepted retire must match the oldest expected entry
   always @(negedge clk) begin
      if (rst_n && ret_en && ret_rdy) begin
         if (exp_q.size() == 0) chk("ret_q_nonempty", 32'(exp_q.size()), 32'd1);
         else begin
            m_exp = exp_q.pop_front();
            chk("sb_ret", 32'(ret), 32'(m_exp[RET_W-1:0]));
            chk("sb_lane", 32'(ret_lane), 32'(m_exp[LW+RET_W-1:RET_W]));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // reset held with random inputs
      for (int c = 0; c < 3; c++) begin
         lane_ret = {LANES*RET_W{1'b0}} | {$urandom, $urandom};
         lane_en  = LANES'($urandom);
         ret_rdy  = 1'($urandom);
         tick;
         chk_out("rst_hold", 1'b0, 0, 0);
         chk("rst_stall", 32'(stall), 32'd0);
         chk("rst_ovf", 32'(ovf), 32'd0);
      end
      idle;
      ret_rdy = 1'b0;
      lane_ret = '0;
      rst_n = 1'b1;
      repeat (2) begin
         tick;
         chk_out("post_rst", 1'b0, 0, 0);
         chk("post_rst_flags", 32'({stall, ovf}), 32'd0);
      end
      // single-lane latency: pushed at edge t, visible after edge t+1
      do_reset;
      ret_rdy = 1'b1;
      drive(1, 'h0A5);
      tick;
      idle;
      chk("lat_t_en", 32'(ret_en), 32'd0);
      tick;
      chk_out("lat_t1", 1'b1, 'h0A5, 1);
      tick;
      chk("lat_done_en", 32'(ret_en), 32'd0);
      chk("lat_q", 32'(exp_q.size()), 32'd0);
      // round-robin across three lanes
      do_reset;
      ret_rdy = 1'b1;
      for (int l = 0; l < LANES; l++) drive(l, 'h10 * (l + 1));
      tick;
      for (int l = 0; l < LANES; l++) drive(l, 'h10 * (l + 1) + 1);
      for (int l = 0; l < LANES; l++) begin
         m_exp = exp_q.pop_back();
         exp_q.insert(LANES, m_exp);
      end
      tick;
      idle;
      chk_out("rr_first", 1'b1, 'h10, 0);
      drain;
      chk("rr_done_en", 32'(ret_en), 32'd0);
      // backpressure holds the output and its FIFO
      do_reset;
      drive(0, 'h10);
      tick;
      drive(0, 'h11);
      tick;
      idle;
      chk_out("bp_load", 1'b1, 'h10, 0);
      repeat (5) begin
         tick;
         chk_out("bp_hold", 1'b1, 'h10, 0);
      end
      ret_rdy = 1'b1;
      tick;
      chk_out("bp_next", 1'b1, 'h11, 0);
      tick;
      chk_out("bp_empty", 1'b0, 'h11, 0);
      chk("bp_q", 32'(exp_q.size()), 32'd0);
      // stall and sticky overflow on lane 0
      do_reset;
      for (int k = 0; k < 6; k++) begin
         drive(0, 'h40 + k, k < 5);
         tick;
         chk("so_stall", 32'(stall), 32'(k >= 3));
         chk("so_ovf", 32'(ovf), 32'(k == 5));
      end
      idle;
      tick;
      chk_out("so_held", 1'b1, 'h40, 0);
      chk("so_ovf_sticky", 32'(ovf), 32'd1);
      ret_rdy = 1'b1;
      drain;
      chk("so_ovf_after", 32'(ovf), 32'd1);
      chk("so_stall_after", 32'(stall), 32'd0);
      chk("so_en_after", 32'(ret_en), 32'd0);
      // full lane 2 with push on the popping edge, then reset mid-drain
      do_reset;
      chk("fp_ovf_cleared", 32'(ovf), 32'd0);
      for (int k = 0; k < 5; k++) begin
         drive(2, 'h50 + k);
         tick;
      end
      chk_out("fp_full", 1'b1, 'h50, 2);
      chk("fp_full_stall", 32'(stall), 32'b100);
      drive(2, 'h55);
      ret_rdy = 1'b1;
      tick;
      idle;
      chk_out("fp_swap", 1'b1, 'h51, 2);
      chk("fp_swap_ovf", 32'(ovf), 32'd0);
      chk("fp_swap_stall", 32'(stall), 32'b100);
      tick;
      chk_out("fp_d1", 1'b1, 'h52, 2);
      chk("fp_d1_stall", 32'(stall), 32'b100);
      tick;
      chk_out("fp_d2", 1'b1, 'h53, 2);
      chk("fp_d2_stall", 32'(stall), 32'd0);
      rst_n = 1'b0;
      #1;
      chk_out("fp_rst", 1'b0, 0, 0);
      chk("fp_rst_flags", 32'({stall, ovf}), 32'd0);
      exp_q.delete();
      tick;
      rst_n = 1'b1;
      repeat (4) begin
         tick;
         chk("fp_after_en", 32'(ret_en), 32'd0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
